// File: rtl/system2m_perf_trigger.sv
// system2m_perf_trigger
// Turns per-section start/done pulses and a global clear request into single
// Avalon-MM word writes to a perf-counter block. Every event sets a pending
// bit; a fixed-priority arbiter issues one write per command through a
// two-state IDLE/WRITE FSM that holds the bus stable under waitrequest.
// Optional macro PERF_TRIGGER_OVERFLOW_EN builds the dropped-event tracking
// (overflow flag and saturating drop_count); without it those ports read 0.
module system2m_perf_trigger #(
   parameter int         SECTIONS  = 4,
   parameter logic [3:0] BASE_ADDR = 4'd0
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                enable,
   input  logic [SECTIONS-1:0] sec_start,
   input  logic [SECTIONS-1:0] sec_done,
   input  logic                clr_req,
   output logic [3:0]          address,
   output logic                write,
   output logic [31:0]         writedata,
   input  logic                waitrequest,
   output logic                busy,
   output logic                overflow,
   output logic [7:0]          drop_count,
   input  logic                ovf_clr
);

   typedef enum logic {IDLE, WRITE} state_t;

   state_t              state, state_next;
   logic                pend_clr, pend_clr_next;
   logic [SECTIONS-1:0] pend_stop, pend_stop_next;
   logic [SECTIONS-1:0] pend_go, pend_go_next;
   logic                ev_clr;
   logic [SECTIONS-1:0] ev_stop, ev_go;
   logic                gnt_clr, gnt_any, found;
   logic [SECTIONS-1:0] gnt_stop, gnt_go;
   logic [3:0]          gnt_addr;
   logic [31:0]         gnt_data;
   logic                clr_window;

   assign ev_clr  = enable & clr_req;
   assign ev_stop = {SECTIONS{enable}} & sec_done;
   assign ev_go   = {SECTIONS{enable}} & sec_start;
   assign gnt_any = gnt_clr | (|gnt_stop) | (|gnt_go);

   // A clear that is arriving or still waiting for its grant supersedes the
   // section commands queued before it.
   assign clr_window = ev_clr | (pend_clr & ~gnt_clr);

   // Next state and fixed-priority grant: CLR, then STOP[0..], then GO[0..].
   always_comb begin
      state_next = state;
      gnt_clr    = 1'b0;
      gnt_stop   = '0;
      gnt_go     = '0;
      gnt_addr   = address;
      gnt_data   = writedata;
      found      = 1'b0;
      case (state)
         IDLE: begin
            if (pend_clr) begin
               gnt_clr  = 1'b1;
               gnt_addr = BASE_ADDR;
               gnt_data = 32'd1;
               found    = 1'b1;
            end
            for (int s = 0; s < SECTIONS; s++) begin
               if (!found && pend_stop[s]) begin
                  found       = 1'b1;
                  gnt_stop[s] = 1'b1;
                  gnt_addr    = BASE_ADDR + 4'(4 * s);
                  gnt_data    = 32'd0;
               end
            end
            for (int s = 0; s < SECTIONS; s++) begin
               if (!found && pend_go[s]) begin
                  found     = 1'b1;
                  gnt_go[s] = 1'b1;
                  gnt_addr  = BASE_ADDR + 4'(4 * s) + 4'd1;
                  gnt_data  = 32'd0;
               end
            end
            if (found) state_next = WRITE;
         end
         WRITE: begin
            if (!waitrequest) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Pending-bit update: a new event always wins over the grant clearing it.
   // STOPs are discarded for the whole clear window; GOs queued before the
   // clear request are discarded, a GO arriving with it is kept, and GOs
   // arriving while the clear still waits for its grant are discarded.
   always_comb begin
      pend_clr_next  = (pend_clr & ~gnt_clr) | ev_clr;
      pend_stop_next = clr_window ? '0 : ((pend_stop & ~gnt_stop) | ev_stop);
      pend_go_next   = (pend_go & ~gnt_go) | ev_go;
      if (ev_clr)
         pend_go_next = ev_go;
      else if (pend_clr & ~gnt_clr)
         pend_go_next = pend_go;
   end

   // State, pending bits and the registered bus command.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= IDLE;
         pend_clr  <= 1'b0;
         pend_stop <= '0;
         pend_go   <= '0;
         address   <= 4'd0;
         writedata <= 32'd0;
      end else begin
         state     <= state_next;
         pend_clr  <= pend_clr_next;
         pend_stop <= pend_stop_next;
         pend_go   <= pend_go_next;
         if (gnt_any) begin
            address   <= gnt_addr;
            writedata <= gnt_data;
         end
      end
   end

   assign write = (state == WRITE);
   assign busy  = (state == WRITE) | pend_clr | (|pend_stop) | (|pend_go);

`ifdef PERF_TRIGGER_OVERFLOW_EN
   logic                drop_clr;
   logic [SECTIONS-1:0] drop_stop, drop_go;
   logic [9:0]          drop_sum;

   function automatic logic [7:0] sat_u8(input logic [9:0] v);
      return (v > 10'd255) ? 8'hFF : v[7:0];
   endfunction

   // Events hitting an already-pending, ungranted bit are lost; superseded
   // commands inside a clear window are not counted.
   assign drop_clr  = ev_clr & pend_clr & ~gnt_clr;
   assign drop_stop = clr_window ? '0 : (ev_stop & pend_stop & ~gnt_stop);
   assign drop_go   = clr_window ? '0 : (ev_go & pend_go & ~gnt_go);
   assign drop_sum  = {2'b00, drop_count} + 10'($countones({drop_clr, drop_stop, drop_go}));

   // Sticky overflow and saturating drop counter; clear beats a new drop.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         overflow   <= 1'b0;
         drop_count <= 8'd0;
      end else if (ovf_clr) begin
         overflow   <= 1'b0;
         drop_count <= 8'd0;
      end else if (drop_clr | (|drop_stop) | (|drop_go)) begin
         overflow   <= 1'b1;
         drop_count <= sat_u8(drop_sum);
      end
   end
`else
   logic unused_ovf_clr;

   assign unused_ovf_clr = ovf_clr;
   assign overflow       = 1'b0;
   assign drop_count     = 8'd0;
`endif

endmodule

// File: tb/tb_system2m_perf_trigger.sv
// Bench for system2m_perf_trigger: directed scenarios followed by a random
// run, all compared every cycle against a command-level reference model.
module tb_system2m_perf_trigger;

`ifdef PERF_TRIGGER_OVERFLOW_EN
   localparam bit OVF_EN = 1'b1;
`else
   localparam bit OVF_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset_n, enable, clr_req, waitrequest, ovf_clr;
   logic [3:0]  sec_start, sec_done, address;
   logic        write, busy, overflow;
   logic [31:0] writedata;
   logic [7:0]  drop_count;

   int errors = 0;
   int checks = 0;

   // Reference model: command k = 0 is CLR, 1..4 STOP[s], 5..8 GO[s].
   int          m_fl, n_fl;          // command on the bus, -1 when idle
   bit [8:0]    m_p, n_p;            // pending commands
   logic [3:0]  m_addr, n_addr;
   logic [31:0] m_data, n_data;
   int          m_drops, n_drops;
   bit          m_ovf, n_ovf;
   int          go0_writes;
   logic        prev_wr;

   always #5 clk = ~clk;

   system2m_perf_trigger #(.SECTIONS(4), .BASE_ADDR(4'd0)) dut (
      .clk(clk), .reset_n(reset_n), .enable(enable),
      .sec_start(sec_start), .sec_done(sec_done), .clr_req(clr_req),
      .address(address), .write(write), .writedata(writedata),
      .waitrequest(waitrequest), .busy(busy), .overflow(overflow),
      .drop_count(drop_count), .ovf_clr(ovf_clr)
   );

   function automatic logic [3:0] cmd_addr(input int k);
      int a;
      if (k == 0)     a = 0;
      else if (k < 5) a = 4 * (k - 1);
      else            a = 4 * (k - 5) + 1;
      return 4'(a);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_fl = -1; m_p = '0; m_addr = 4'd0; m_data = 32'd0; m_drops = 0; m_ovf = 1'b0;
   endtask

   task automatic model_calc();
      bit [8:0] e;
      int g, nd;
      bit keep, win;
      n_fl = m_fl; n_p = m_p; n_addr = m_addr; n_data = m_data;
      n_drops = m_drops; n_ovf = m_ovf;
      if (!reset_n) begin
         n_fl = -1; n_p = '0; n_addr = 4'd0; n_data = 32'd0; n_drops = 0; n_ovf = 1'b0;
         return;
      end
      e[0] = enable & clr_req;
      for (int s = 0; s < 4; s++) begin
         e[1 + s] = enable & sec_done[s];
         e[5 + s] = enable & sec_start[s];
      end
      g = -1;
      if (m_fl < 0) begin
         for (int k = 0; k < 9; k++) if (g < 0 && m_p[k]) g = k;
      end
      if (m_fl >= 0 && !waitrequest) n_fl = -1;
      if (g >= 0) begin
         n_fl = g; n_addr = cmd_addr(g); n_data = (g == 0) ? 32'd1 : 32'd0;
      end
      nd  = 0;
      win = e[0] || (m_p[0] && g != 0);
      for (int k = 0; k < 9; k++) begin
         keep = m_p[k] && (g != k);
         if (k >= 1 && k <= 4 && win) begin
            n_p[k] = 1'b0;
         end else if (k >= 5 && e[0]) begin
            n_p[k] = e[k];
         end else if (k >= 5 && m_p[0] && g != 0) begin
            n_p[k] = m_p[k];
         end else begin
            n_p[k] = keep || e[k];
            if (keep && e[k]) nd++;
         end
      end
      if (ovf_clr) begin
         n_ovf = 1'b0; n_drops = 0;
      end else if (nd > 0) begin
         n_ovf = 1'b1; n_drops = (m_drops + nd > 255) ? 255 : m_drops + nd;
      end
      if (!OVF_EN) begin
         n_ovf = 1'b0; n_drops = 0;
      end
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".write"}, write, (m_fl >= 0));
      chk({tag, ".address"}, address, m_addr);
      chk({tag, ".writedata"}, writedata, m_data);
      chk({tag, ".busy"}, busy, ((m_fl >= 0) || (m_p != 0)));
      chk({tag, ".overflow"}, overflow, m_ovf);
      chk({tag, ".drop_count"}, drop_count, m_drops);
   endtask

   task automatic tick(input string tag);
      model_calc();
      @(posedge clk);
      m_fl = n_fl; m_p = n_p; m_addr = n_addr; m_data = n_data;
      m_drops = n_drops; m_ovf = n_ovf;
      #1;
      check_all(tag);
      if (write && !prev_wr && address == 4'd1) go0_writes++;
      prev_wr = write;
   endtask

   task automatic quiet();
      sec_start = 4'd0; sec_done = 4'd0; clr_req = 1'b0; ovf_clr = 1'b0;
   endtask

   initial begin
      reset_n = 1'b0; enable = 1'b1; waitrequest = 1'b0; prev_wr = 1'b0; go0_writes = 0;
      quiet();
      model_reset();
      tick("rst"); tick("rst");
      chk("reset.write", write, 0);
      chk("reset.busy", busy, 0);
      chk("reset.address", address, 0);
      reset_n = 1'b1;
      tick("run");

      // start[1] from idle: write two cycles later, one cycle long
      sec_start = 4'b0010; tick("go1"); quiet();
      chk("go1.early", write, 0);
      tick("go1");
      chk("go1.write", write, 1); chk("go1.addr", address, 4'd5); chk("go1.data", writedata, 0);
      tick("go1");
      chk("go1.single", write, 0);

      // done[2] stalled three cycles: held for four
      sec_done = 4'b0100; tick("stop2"); quiet(); tick("stop2");
      chk("stop2.write", write, 1);
      waitrequest = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick("stop2.hold");
         chk("stop2.held", write, 1); chk("stop2.addr", address, 4'd8);
      end
      waitrequest = 1'b0; tick("stop2");
      chk("stop2.done", write, 0); chk("stop2.busy", busy, 0);

      // clear with coincident done[0] and start[3]
      clr_req = 1'b1; sec_done = 4'b0001; sec_start = 4'b1000; tick("clr"); quiet();
      tick("clr");
      chk("clr.addr", address, 4'd0); chk("clr.data", writedata, 1); chk("clr.write", write, 1);
      tick("clr"); chk("clr.gap", write, 0);
      tick("clr"); chk("clr.go3", address, 4'd13); chk("clr.go3w", write, 1);
      tick("clr"); chk("clr.end", busy, 0);

      // start[0] twice while pending behind a stalled write
      sec_done = 4'b1000; tick("dbl"); quiet(); tick("dbl");
      waitrequest = 1'b1;
      sec_start = 4'b0001; tick("dbl"); quiet(); tick("dbl");
      sec_start = 4'b0001; tick("dbl"); quiet();
      go0_writes = 0; waitrequest = 1'b0;
      for (int i = 0; i < 10; i++) tick("dbl.drain");
      chk("dbl.go0_writes", go0_writes, 1);
      chk("dbl.overflow", overflow, OVF_EN);
      chk("dbl.drops", drop_count, OVF_EN ? 1 : 0);
      ovf_clr = 1'b1; tick("dbl.clr"); quiet();

      // enable low blocks events
      enable = 1'b0; sec_start = 4'b1000; tick("en"); quiet(); tick("en"); tick("en");
      chk("en.write", write, 0); chk("en.busy", busy, 0);
      enable = 1'b1;

      // reset during a stalled write
      sec_done = 4'b0010; tick("ar"); quiet(); tick("ar");
      chk("ar.addr", address, 4'd4);
      waitrequest = 1'b1; tick("ar");
      #2 reset_n = 1'b0;
      #1;
      chk("ar.write_async", write, 0); chk("ar.busy_async", busy, 0);
      model_reset(); prev_wr = 1'b0;
      tick("ar.low"); tick("ar.low");
      #3 reset_n = 1'b1; waitrequest = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick("ar.after");
         chk("ar.no_replay", write, 0); chk("ar.idle", busy, 0);
      end

      // 300 drops saturate, then clear wins over a coincident drop
      sec_done = 4'b1000; tick("sat"); quiet(); tick("sat");
      waitrequest = 1'b1; sec_start = 4'b0001;
      for (int i = 0; i < 301; i++) tick("sat.drop");
      chk("sat.count", drop_count, OVF_EN ? 255 : 0);
      chk("sat.ovf", overflow, OVF_EN);
      ovf_clr = 1'b1; tick("sat.clr"); ovf_clr = 1'b0;
      chk("sat.clr_count", drop_count, 0); chk("sat.clr_ovf", overflow, 0);
      quiet(); waitrequest = 1'b0;
      for (int i = 0; i < 10; i++) tick("sat.drain");
      chk("sat.idle", busy, 0);

      // random traffic
      for (int i = 0; i < 1500; i++) begin
         enable      = ($urandom_range(0, 9) != 0);
         sec_start   = 4'($urandom & $urandom & $urandom);
         sec_done    = 4'($urandom & $urandom & $urandom);
         clr_req     = ($urandom_range(0, 31) == 0);
         waitrequest = ($urandom_range(0, 2) == 0);
         ovf_clr     = ($urandom_range(0, 49) == 0);
         tick("rnd");
      end
      quiet(); waitrequest = 1'b0;
      for (int i = 0; i < 40; i++) tick("rnd.drain");
      chk("rnd.idle", busy, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
